// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone instruction/data memory responder.
package wb_pkg;

  localparam int unsigned BUS_W      = 32;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_imem_ram.sv
// Single-port synchronous RAM with byte write enables; registered read of idx every cycle.
module wb_imem_ram
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] sel,
  input  logic [IDX_W-1:0]      idx,
  input  logic [BUS_W-1:0]      wdata,
  output logic [BUS_W-1:0]      rdata
);

  logic [BUS_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (sel[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/wb_imem_resp.sv
// Wishbone-classic memory responder: single transfers, programmable wait states,
// akn or err termination, saturating count of acknowledged transfers.
module wb_imem_resp
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cyc_in,
  input  logic             stb_in,
  input  logic             we_in,
  input  logic [31:0]      addr_in,
  input  logic [31:0]      data_in,
  input  logic [3:0]       sel_in,
  output logic             akn_out,
  output logic             err_out,
  output logic [31:0]      data_out,
  output logic             busy_out,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * WORD_BYTES);
  localparam logic [3:0]  WAIT_LD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  wb_state_e        state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic             latch;
  logic             we_q, err_q;
  logic [3:0]       sel_q;
  logic [31:0]      wdata_q, hold_q;
  logic [IDX_W-1:0] idx_q, req_idx, ram_idx;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      off;
  logic             req_err;
  logic             ram_we;
  logic [31:0]      ram_rdata;

  // Addresses below BASE_ADDR wrap to a large offset and fail the span check.
  assign off     = addr_in - BASE_ADDR;
  assign req_err = (addr_in[1:0] != 2'b00) || (off >= SPAN);
  assign req_idx = off[IDX_W+1:2];

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    latch   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cyc_in && stb_in) begin
          latch   = 1'b1;
          wait_d  = WAIT_LD;
          state_d = (WAIT_CYCLES > 0) ? StWait : StResp;
        end
      end
      StWait: begin
        if (!cyc_in) begin
          state_d = StIdle;
        end else if (wait_q == 4'd0) begin
          state_d = StResp;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      wait_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (latch) begin
        we_q    <= we_in;
        err_q   <= req_err;
        sel_q   <= sel_in;
        wdata_q <= data_in;
        idx_q   <= req_idx;
      end
      if (state_q == StResp) begin
        hold_q <= data_out;
      end
      if (akn_out && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // The RAM reads the live request index in IDLE so zero-wait reads still land in RESP.
  assign ram_idx = (state_q == StIdle) ? req_idx : idx_q;
  assign ram_we  = (state_q == StResp) && we_q && !err_q && !rst;

  wb_imem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .sel  (sel_q),
    .idx  (ram_idx),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  assign busy_out = (state_q != StIdle);
  assign akn_out  = (state_q == StResp) && !err_q;
  assign err_out  = (state_q == StResp) && err_q;
  assign xfer_cnt = cnt_q;

  always_comb begin
    data_out = hold_q;
    if (state_q == StResp) begin
      if (err_q) begin
        data_out = '0;
      end else if (!we_q) begin
        data_out = ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_wb_imem_resp.sv
// Scoreboard bench: three responders (1, 3 and 0 wait states) against a behavioural model.
module tb_wb_imem_resp;

  localparam int N     = 3;
  localparam int DEPTH = 1024;
  localparam int C2    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic        rst  [N];
  logic        cyc  [N];
  logic        stb  [N];
  logic        we   [N];
  logic [31:0] addr [N];
  logic [31:0] wdat [N];
  logic [3:0]  sel  [N];
  logic        akn  [N];
  logic        err  [N];
  logic        busy [N];
  logic [31:0] rdat [N];
  logic [15:0] cnt0, cnt1;
  logic [C2-1:0] cnt2;

  wb_imem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1), .BASE_ADDR(32'h0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst[0]), .cyc_in(cyc[0]), .stb_in(stb[0]), .we_in(we[0]),
    .addr_in(addr[0]), .data_in(wdat[0]), .sel_in(sel[0]), .akn_out(akn[0]),
    .err_out(err[0]), .data_out(rdat[0]), .busy_out(busy[0]), .xfer_cnt(cnt0)
  );
  wb_imem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3), .BASE_ADDR(32'h2000), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst[1]), .cyc_in(cyc[1]), .stb_in(stb[1]), .we_in(we[1]),
    .addr_in(addr[1]), .data_in(wdat[1]), .sel_in(sel[1]), .akn_out(akn[1]),
    .err_out(err[1]), .data_out(rdat[1]), .busy_out(busy[1]), .xfer_cnt(cnt1)
  );
  wb_imem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(32'h0), .CNT_W(C2)) u_dut2 (
    .clk(clk), .rst(rst[2]), .cyc_in(cyc[2]), .stb_in(stb[2]), .we_in(we[2]),
    .addr_in(addr[2]), .data_in(wdat[2]), .sel_in(sel[2]), .akn_out(akn[2]),
    .err_out(err[2]), .data_out(rdat[2]), .busy_out(busy[2]), .xfer_cnt(cnt2)
  );

  function automatic int unsigned wait_of(input int i);
    case (i)
      0: return 1;
      1: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] base_of(input int i);
    return (i == 1) ? 32'h2000 : 32'h0;
  endfunction

  function automatic int unsigned cnt_max(input int i);
    return (i == 2) ? 15 : 65535;
  endfunction

  function automatic logic [31:0] cnt_of(input int i);
    case (i)
      0: return {16'h0, cnt0};
      1: return {16'h0, cnt1};
      default: return {28'h0, cnt2};
    endcase
  endfunction

  // Reference model: word arrays per responder, plus which words hold a defined value.
  logic [31:0] mmem  [N][DEPTH];
  bit          known [N][DEPTH];
  int unsigned mcnt  [N];

  typedef struct {
    int          inst;
    bit          is_err;
    bit          chk_data;
    logic [31:0] data;
    int unsigned cyc;
    int unsigned cnt;
  } exp_t;

  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic fail(input string name, input int info);
    n_chk++;
    n_err++;
    $display("FAIL %s: info %0d (cycle %0d)", name, info, cyc_n);
  endtask

  // Sampled in cycle 'at': termination is due at at+1+wait.
  task automatic model_req(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int unsigned at);
    exp_t   e;
    longint off;
    int     idx;
    off        = longint'(a) - longint'(base_of(i));
    e.inst     = i;
    e.cyc      = at + 1 + wait_of(i);
    e.cnt      = mcnt[i];
    e.is_err   = (a % 4 != 0) || (off < 0) || (off >= DEPTH * 4);
    e.chk_data = 1'b0;
    e.data     = 32'h0;
    if (e.is_err) begin
      e.chk_data = 1'b1;
    end else begin
      idx = int'(off / 4);
      if (!w) begin
        e.chk_data = known[i][idx];
        e.data     = mmem[i][idx];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) mmem[i][idx][8*b +: 8] = d[8*b +: 8];
        end
        known[i][idx] = known[i][idx] || (s == 4'hF);
      end
      if (mcnt[i] < cnt_max(i)) mcnt[i]++;
    end
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc_n) begin
      e = sb.pop_front();
      fail("missing_termination", e.inst);
    end
    for (int i = 0; i < N; i++) begin
      if (akn[i] && err[i]) fail("akn_err_both", i);
      if (akn[i] || err[i]) begin
        if (sb.size() == 0) begin
          fail("unexpected_termination", i);
        end else begin
          e = sb.pop_front();
          check("resp_inst", 32'(i), 32'(e.inst));
          check("resp_cycle", cyc_n, e.cyc);
          check("resp_err", 32'(err[i]), 32'(e.is_err));
          check("resp_akn", 32'(akn[i]), 32'(!e.is_err));
          check("resp_cnt", cnt_of(i), e.cnt);
          if (e.chk_data) check("resp_data", rdat[i], e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    step();
    cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; addr[i] = a; wdat[i] = d; sel[i] = s;
    model_req(i, w, a, d, s, cyc_n);
    for (int k = 0; k <= int'(wait_of(i)); k++) begin
      step();
      // Bus lines other than cyc change freely while the request is in flight.
      stb[i] = 1'b0; we[i] = 1'($urandom); addr[i] = $urandom; wdat[i] = $urandom;
      sel[i] = 4'($urandom);
    end
    cyc[i] = 1'b0;
  endtask

  task automatic rand_xfer();
    int          i;
    int          r;
    logic [31:0] a;
    logic [31:0] w;
    i = int'($urandom_range(2, 0));
    r = int'($urandom_range(9, 0));
    w = 32'($urandom_range(15, 0)) * 4;
    if (r < 8)       a = base_of(i) + w;
    else if (r == 8) a = base_of(i) + w + 32'($urandom_range(3, 1));
    else             a = (($urandom & 1) != 0) ? base_of(i) + 32'h1000 + w : base_of(i) - 4;
    xfer(i, 1'($urandom), a, $urandom, 4'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
      addr[i] = '0; wdat[i] = '0; sel[i] = '0; mcnt[i] = 0;
    end
    repeat (3) step();
    for (int i = 0; i < N; i++) begin
      check("reset_akn", 32'(akn[i]), 32'h0);
      check("reset_err", 32'(err[i]), 32'h0);
      check("reset_data", rdat[i], 32'h0);
      check("reset_busy", 32'(busy[i]), 32'h0);
      check("reset_cnt", cnt_of(i), 32'h0);
      rst[i] = 1'b0;
    end

    // Give every responder a defined image in its first 16 words.
    for (int i = 0; i < N; i++)
      for (int w = 0; w < 16; w++)
        xfer(i, 1'b1, base_of(i) + 32'(w * 4), $urandom, 4'hF);

    // One wait state: program word read, then hold of data_out in IDLE.
    xfer(0, 1'b1, 32'h0, 32'h0000_0013, 4'hF);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    check("hold_data", rdat[0], 32'h0000_0013);
    check("hold_akn", 32'(akn[0]), 32'h0);

    // Partial byte write, then sel=0 write leaves it alone.
    xfer(0, 1'b1, 32'h8, 32'h0, 4'hF);
    xfer(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'b0011);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'h0);
    xfer(0, 1'b1, 32'h8, 32'h1111_1111, 4'b0000);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'h0);

    // Misaligned and out-of-range terminations.
    xfer(0, 1'b0, 32'h2, 32'h0, 4'h0);
    xfer(0, 1'b0, 32'h1000, 32'h0, 4'h0);
    xfer(0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF);
    xfer(1, 1'b0, 32'h1FFC, 32'h0, 4'h0);
    xfer(1, 1'b0, 32'h3000, 32'h0, 4'h0);

    // Abort a three-wait write to word 1 in its second wait cycle.
    step();
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h2004;
    wdat[1] = 32'hBAD0_BAD0; sel[1] = 4'hF;
    step();
    stb[1] = 1'b0;
    step();
    cyc[1] = 1'b0;
    step();
    check("abort_busy", 32'(busy[1]), 32'h0);
    check("abort_term", 32'(akn[1] | err[1]), 32'h0);
    xfer(1, 1'b0, 32'h2004, 32'h0, 4'h0);

    // Zero wait states with cyc/stb held for 8 cycles: requests land every other cycle.
    step();
    for (int k = 0; k < 8; k++) begin
      cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0;
      addr[2] = 32'($urandom_range(15, 0)) * 4;
      if (k % 2 == 0) model_req(2, 1'b0, addr[2], 32'h0, 4'h0, cyc_n);
      step();
    end
    cyc[2] = 1'b0; stb[2] = 1'b0;

    // Reset during WAIT of a write: dropped, outputs cleared.
    step();
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10;
    wdat[0] = 32'h1234_5678; sel[0] = 4'hF;
    step();
    rst[0] = 1'b1; cyc[0] = 1'b0; stb[0] = 1'b0;
    step();
    rst[0] = 1'b0;
    mcnt[0] = 0;
    check("rst_wait_akn", 32'(akn[0]), 32'h0);
    check("rst_wait_err", 32'(err[0]), 32'h0);
    check("rst_wait_data", rdat[0], 32'h0);
    check("rst_wait_busy", 32'(busy[0]), 32'h0);
    check("rst_wait_cnt", cnt_of(0), 32'h0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0);

    // Reset during RESP of a zero-wait write: akn shows, the write is dropped.
    step();
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h20;
    wdat[2] = 32'hCAFE_F00D; sel[2] = 4'hF;
    e.inst = 2; e.is_err = 1'b0; e.chk_data = 1'b0; e.data = 32'h0;
    e.cyc = cyc_n + 1; e.cnt = mcnt[2];
    sb.push_back(e);
    step();
    rst[2] = 1'b1; cyc[2] = 1'b0; stb[2] = 1'b0;
    step();
    rst[2] = 1'b0;
    mcnt[2] = 0;
    check("rst_resp_cnt", cnt_of(2), 32'h0);
    xfer(2, 1'b0, 32'h20, 32'h0, 4'h0);

    // Random traffic; the 4-bit counter on the zero-wait responder saturates.
    for (int n = 0; n < 60; n++) rand_xfer();
    for (int n = 0; n < 20; n++) xfer(2, 1'b0, 32'($urandom_range(15, 0)) * 4, 32'h0, 4'h0);

    repeat (6) step();
    if (sb.size() != 0) fail("scoreboard_leftover", sb.size());
    for (int i = 0; i < N; i++) check("final_cnt", cnt_of(i), mcnt[i]);
    check("final_cnt_saturated", cnt_of(2), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
